// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Holds the reset PC, the FSM encoding and the buffered {pc, inst} entry layout.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC  = 32'h1c00_0000;
    localparam int          BUF_DEPTH = 2;

    localparam logic TRUE   = 1'b1;
    localparam logic FALSE  = 1'b0;
    localparam logic RestEn = 1'b1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Word-align by masking so every address bit participates in the expression.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hffff_fffc;
    endfunction

endpackage

// File: rtl/if_stage_inst_buffer.sv
// Two-entry FIFO of fetched {pc, inst} pairs sitting between the SRAM and decode.
// Clear wins over push and pop so a redirect leaves the queue empty.
module inst_buffer
    import if_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    input  logic         i_clear,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [BUF_DEPTH];
    logic         r_head;
    logic         r_tail;
    logic [1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset == RestEn) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= i_push_entry;
                r_tail        <= ~r_tail;
            end
            if (w_do_pop) begin
                r_head <= ~r_head;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues SRAM reads under a credit limit,
// and hands {pc, inst} pairs to decode; redirect/flush discard all wrong-path work.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    output logic        right_valid,
    input  logic        right_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    logic [0:0]   r_state;
    logic [31:0]  r_pc;
    logic         r_inflight;
    logic [31:0]  r_inflight_pc;

    logic         w_kill;
    logic [31:0]  w_fetch_pc;
    logic [31:0]  w_fetch_aligned;
    logic         w_pop;
    logic         w_inflight_live;
    logic [1:0]   w_count;
    logic [1:0]   w_count_eff;
    logic [2:0]   w_occupancy;
    logic         w_credit_ok;
    logic         w_issue;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_kill          = redirect_valid | flush;
    assign w_fetch_pc      = redirect_valid ? redirect_pc : r_pc;
    assign w_fetch_aligned = word_align(w_fetch_pc);

    // A killed cycle sees an empty queue: the buffer is cleared, the returning
    // word is dropped and any pop is void, so a redirect always gets a credit.
    assign w_pop           = right_valid & right_ready & ~w_kill;
    assign w_inflight_live = r_inflight & ~w_kill;
    assign w_count_eff     = w_kill ? 2'd0 : w_count;
    assign w_occupancy     = {1'b0, w_count_eff} + {2'b00, w_inflight_live} - {2'b00, w_pop};
    assign w_credit_ok     = (w_occupancy < 3'd2);

    assign w_issue = ((r_state == ST_RUN) | redirect_valid)
                   & ~(flush & ~redirect_valid)
                   & w_credit_ok
                   & ~reset;

    assign inst_sram_en   = w_issue;
    assign inst_sram_addr = w_fetch_aligned;

    always_ff @(posedge clk) begin
        if (reset == RestEn) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_inflight    <= FALSE;
            r_inflight_pc <= '0;
        end else begin
            if (redirect_valid) begin
                r_state <= ST_RUN;
            end else if (flush) begin
                r_state <= ST_HALT;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= w_fetch_aligned + 32'd4;
                r_inflight_pc <= w_fetch_aligned;
            end else if (redirect_valid) begin
                r_pc <= w_fetch_aligned;
            end
        end
    end

    assign w_push_entry.pc   = r_inflight_pc;
    assign w_push_entry.inst = inst_sram_rdata;

    inst_buffer u_buf (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_inflight_live),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_clear      (w_kill),
        .o_head       (w_head),
        .o_count      (w_count)
    );

    assign right_valid = (w_count != 2'd0);
    assign out_pc      = w_head.pc;
    assign out_inst    = w_head.inst;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of per-cycle vectors plus hand-written
// sequences for halt/resume and a streaming in-order scoreboard under backpressure.
module tb_if_stage;

    localparam logic [31:0] B = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        right_valid;
    logic        right_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    int nVectors = 0;
    int nMiscompares = 0;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        logic        rdy;
        logic        expEn;
        logic [31:0] expAddr;
        logic        chkRv;
        logic        expRv;
        logic        chkOut;
        logic [31:0] expPc;
        logic [31:0] expInst;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .right_valid     (right_valid),
        .right_ready     (right_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst)
    );

    // SRAM model: each word holds the bitwise complement of its address.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= ~inst_sram_addr;
    end

    always @(negedge clk) begin
        if (!reset && dut.w_count > 2'd2) begin
            nMiscompares++;
            $display("[TB] FAIL count_bound: got %0d, required <= 2", dut.w_count);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                                 input logic fl, input logic rdy);
        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        flush          = fl;
        right_ready    = rdy;
        #1;
    endtask

    task automatic tv(input logic rst, input logic rv, input logic [31:0] rpc, input logic fl,
                      input logic rdy, input logic en, input logic [31:0] addr,
                      input logic ckRv, input logic rvE, input logic ckOut,
                      input logic [31:0] opc, input logic [31:0] oinst);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.fl = fl; v.rdy = rdy;
        v.expEn = en; v.expAddr = addr; v.chkRv = ckRv; v.expRv = rvE;
        v.chkOut = ckOut; v.expPc = opc; v.expInst = oinst;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] expNext;
        int          accepted;
        bit          seen;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; flush = 1'b0; right_ready = 1'b1;

        tv(1,0,0,0,1, 0,0,        0,0, 0,0,0);
        tv(1,0,0,0,1, 0,0,        1,0, 1,0,0);
        tv(0,0,0,0,1, 1,B,        1,0, 0,0,0);
        tv(0,0,0,0,1, 1,B+32'h4,  1,0, 0,0,0);
        tv(0,0,0,0,1, 1,B+32'h8,  1,1, 1,B,~B);
        tv(0,0,0,0,1, 1,B+32'hc,  1,1, 1,B+32'h4,~(B+32'h4));
        for (int i = 0; i < 5; i++)
            tv(0,0,0,0,0, 0,0,    1,1, 1,B+32'h8,~(B+32'h8));
        tv(0,0,0,0,1, 1,B+32'h10, 1,1, 1,B+32'h8,~(B+32'h8));
        tv(0,0,0,0,1, 1,B+32'h14, 1,1, 1,B+32'hc,~(B+32'hc));
        tv(0,0,0,0,1, 1,B+32'h18, 1,1, 1,B+32'h10,~(B+32'h10));
        tv(0,0,0,0,0, 0,0,        1,1, 1,B+32'h14,~(B+32'h14));
        tv(0,1,B+32'h100,0,0, 1,B+32'h100, 1,1, 1,B+32'h14,~(B+32'h14));
        tv(0,0,0,0,1, 1,B+32'h104, 1,0, 0,0,0);
        tv(0,0,0,0,1, 1,B+32'h108, 1,1, 1,B+32'h100,~(B+32'h100));
        tv(0,0,0,0,1, 1,B+32'h10c, 1,1, 1,B+32'h104,~(B+32'h104));
        tv(0,0,0,1,1, 0,0,         1,1, 1,B+32'h108,~(B+32'h108));
        for (int i = 0; i < 10; i++)
            tv(0,0,0,0,1, 0,0,     1,0, 0,0,0);
        tv(0,1,B+32'h200,0,1, 1,B+32'h200, 1,0, 0,0,0);
        tv(0,0,0,0,1, 1,B+32'h204, 1,0, 0,0,0);
        tv(0,0,0,0,1, 1,B+32'h208, 1,1, 1,B+32'h200,~(B+32'h200));
        tv(0,1,B+32'h102,0,1, 1,B+32'h100, 1,1, 1,B+32'h204,~(B+32'h204));
        tv(0,0,0,0,1, 1,B+32'h104, 1,0, 0,0,0);
        tv(0,0,0,0,1, 1,B+32'h108, 1,1, 1,B+32'h100,~(B+32'h100));
        tv(0,1,32'hffff_fffc,0,1, 1,32'hffff_fffc, 1,1, 1,B+32'h104,~(B+32'h104));
        tv(0,0,0,0,1, 1,32'h0,     1,0, 0,0,0);
        tv(0,0,0,0,1, 1,32'h4,     1,1, 1,32'hffff_fffc,32'h3);
        tv(1,1,B+32'h300,1,1, 0,0, 0,0, 0,0,0);
        tv(0,0,0,0,1, 1,B,         1,0, 1,0,0);
        tv(0,0,0,0,1, 1,B+32'h4,   1,0, 0,0,0);
        tv(0,0,0,0,1, 1,B+32'h8,   1,1, 1,B,~B);
        tv(0,1,B+32'h400,1,1, 1,B+32'h400, 1,1, 1,B+32'h4,~(B+32'h4));
        tv(0,0,0,0,1, 1,B+32'h404, 1,0, 0,0,0);
        tv(0,0,0,0,1, 1,B+32'h408, 1,1, 1,B+32'h400,~(B+32'h400));

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].rv, vecs[k].rpc, vecs[k].fl, vecs[k].rdy);
            nVectors++;
            checkOutput($sformatf("v%0d_en", k), {31'b0, inst_sram_en}, {31'b0, vecs[k].expEn});
            if (vecs[k].expEn)
                checkOutput($sformatf("v%0d_addr", k), inst_sram_addr, vecs[k].expAddr);
            if (vecs[k].chkRv)
                checkOutput($sformatf("v%0d_valid", k), {31'b0, right_valid}, {31'b0, vecs[k].expRv});
            if (vecs[k].chkOut) begin
                checkOutput($sformatf("v%0d_pc", k), out_pc, vecs[k].expPc);
                checkOutput($sformatf("v%0d_inst", k), out_inst, vecs[k].expInst);
            end
        end

        // Flush alone must halt fetching until a redirect; then wait bounded for its data.
        applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            nVectors++;
            checkOutput("halt_en", {31'b0, inst_sram_en}, 32'd0);
            checkOutput("halt_valid", {31'b0, right_valid}, 32'd0);
        end
        applyStimulus(0, 1, 32'h0000_3000, 0, 0);
        nVectors++;
        checkOutput("resume_addr", inst_sram_addr, 32'h0000_3000);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            seen = right_valid;
        end
        nVectors++;
        if (!seen) begin
            nMiscompares++;
            $display("[TB] FAIL resume_timeout: got no valid, required valid within 5 cycles");
        end else begin
            checkOutput("resume_pc", out_pc, 32'h0000_3000);
            checkOutput("resume_inst", out_inst, ~32'h0000_3000);
        end

        // Streaming scoreboard with intermittent backpressure: strictly in order, no gaps.
        applyStimulus(0, 1, 32'h0000_2000, 0, 1);
        expNext  = 32'h0000_2000;
        accepted = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0, 0, 0, (i % 3) != 2);
            if (right_valid && right_ready) begin
                nVectors++;
                checkOutput("stream_pc", out_pc, expNext);
                checkOutput("stream_inst", out_inst, ~expNext);
                expNext  = expNext + 32'd4;
                accepted++;
            end
        end
        nVectors++;
        if (accepted < 30) begin
            nMiscompares++;
            $display("[TB] FAIL stream_rate: got %0d accepted, required >= 30", accepted);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
